fpu_fp80_pack_wb: RTL and testbench

- Stage directly downstream of the fp64 square-root datapath.
- Consumes its binary64 result plus its invalid, inexact, overflow and underflow flags through a valid/ready handshake.
- Widens the result to x87 80-bit extended format, classifies the x87 tag, and buffers up to 2 results for the FPU register-stack writeback port.
- Keeps the sticky x87 status-word exception bits, updated on each committed result, and raises the exception-pending (ES) indication.

---
 rtl/fpu_pkg.sv | 33 +++
 rtl/fpu_lzc52.sv | 21 ++
 rtl/fpu_fp80_pack_wb.sv | 167 ++++++++++++++++
 tb/tb_fpu_fp80_pack_wb.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU constants: x87 extended-format field widths, rebias values,
// tag-word encodings, status-word bit positions and canonical mantissas.
package fpu_pkg;

  localparam int FP80_EXP_W  = 15;
  localparam int FP80_MANT_W = 64;
  localparam int FP80_W      = 1 + FP80_EXP_W + FP80_MANT_W;

  // binary64 bias 1023 -> extended bias 16383
  localparam logic [FP80_EXP_W-1:0] EXP_REBIAS_NORM = 15'd15360;
  // subnormal: exponent of leading one p is p - 1074 + 16383
  localparam logic [FP80_EXP_W-1:0] EXP_REBIAS_SUB  = 15'd15309;
  localparam logic [FP80_EXP_W-1:0] EXP_SPECIAL     = 15'h7FFF;

  typedef enum logic [1:0] {
    TW_VALID   = 2'b00,
    TW_ZERO    = 2'b01,
    TW_SPECIAL = 2'b10
  } tagword_e;

  // Status-word exception bit positions within the 6-bit field
  localparam int PE = 5;
  localparam int UE = 4;
  localparam int OE = 3;
  localparam int ZE = 2;
  localparam int DE = 1;
  localparam int IE = 0;

  // Infinity: explicit integer bit only. Quiet NaN: integer bit + quiet bit.
  localparam logic [FP80_MANT_W-1:0] INF_MANT  = 64'h8000_0000_0000_0000;
  localparam logic [FP80_MANT_W-1:0] QNAN_MANT = 64'hC000_0000_0000_0000;

endpackage

// File: rtl/fpu_lzc52.sv
// Leading-one position of a 52-bit fraction, used to normalize binary64
// subnormals. zero_o is set when no bit is set (p_o is then 0).
module fpu_lzc52 (
  input  logic [51:0] f_i,
  output logic [5:0]  p_o,
  output logic        zero_o
);

  // Scan upward; the highest set bit is the last one to write p_o
  always_comb begin
    p_o    = '0;
    zero_o = 1'b1;
    for (int i = 0; i < 52; i++) begin
      if (f_i[i]) begin
        p_o    = 6'(i);
        zero_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/fpu_fp80_pack_wb.sv
// Widens binary64 square-root results to x87 extended format, classifies the
// tag word, buffers two results for register-stack writeback and keeps the
// sticky status-word exception bits.
//
// Handshake: a transfer happens on a clock edge where valid and ready are
// both high; the producer must hold its data stable while valid is high and
// ready is low. in_ready depends only on rst and the fill level, never on
// in_valid, and out_* always present the head entry straight from registers.
module fpu_fp80_pack_wb
  import fpu_pkg::*;
#(
  parameter int TAG_W = 3,
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [63:0]       in_y,
  input  logic              in_invalid,
  input  logic              in_inexact,
  input  logic              in_overflow,
  input  logic              in_underflow,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [79:0]       out_data,
  output logic [1:0]        out_tagword,
  output logic [TAG_W-1:0]  out_tag,
  input  logic [5:0]        cw_mask,
  input  logic              clr_exc,
  output logic [5:0]        sw_exc,
  output logic              exc_pending
);

  localparam logic [1:0] FULL = 2'(DEPTH);

  // Buffer storage and pointers
  logic [FP80_W-1:0] data_q [DEPTH];
  tagword_e          tw_q   [DEPTH];
  logic [TAG_W-1:0]  tag_q  [DEPTH];
  logic [5:0]        flg_q  [DEPTH];
  logic              head_q, tail_q;
  logic [1:0]        count_q, count_d;

  logic [5:0] sw_exc_q, sw_exc_d;
  logic       pend_q;

  logic push, pop;

  // Conversion signals
  logic                   s_in;
  logic [10:0]            e_in;
  logic [51:0]            f_in;
  logic [5:0]             lz_p;
  logic                   lz_zero;
  logic [FP80_EXP_W-1:0]  conv_exp;
  logic [FP80_MANT_W-1:0] conv_mant;
  tagword_e               conv_tw;
  logic [5:0]             in_flags;

  assign s_in = in_y[63];
  assign e_in = in_y[62:52];
  assign f_in = in_y[51:0];

  assign in_ready  = !rst && (count_q != FULL);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_data    = data_q[head_q];
  assign out_tagword = tw_q[head_q];
  assign out_tag     = tag_q[head_q];
  assign sw_exc      = sw_exc_q;
  assign exc_pending = pend_q;

  fpu_lzc52 u_lzc (
    .f_i    (f_in),
    .p_o    (lz_p),
    .zero_o (lz_zero)
  );

  // Classify the incoming binary64 value and build the extended encoding
  always_comb begin
    conv_exp  = '0;
    conv_mant = '0;
    conv_tw   = TW_VALID;
    if (e_in == 11'h7FF) begin
      conv_exp = EXP_SPECIAL;
      conv_tw  = TW_SPECIAL;
      if (f_in == 52'd0) begin
        conv_mant = INF_MANT;
      end else begin
        // NaN payload kept, quiet bit forced so SNaNs become QNaNs
        conv_mant = QNAN_MANT | {2'b00, f_in[50:0], 11'b0};
      end
    end else if (e_in == 11'd0) begin
      if (lz_zero) begin
        conv_tw = TW_ZERO;
      end else begin
        // Extended format has range for every binary64 subnormal: normalize
        conv_exp  = 15'(lz_p) + EXP_REBIAS_SUB;
        conv_mant = {12'b0, f_in} << (6'd63 - lz_p);
      end
    end else begin
      conv_exp  = {4'b0, e_in} + EXP_REBIAS_NORM;
      conv_mant = {1'b1, f_in, 11'b0};
    end
  end

  // Pack upstream flags into status-word bit order
  always_comb begin
    in_flags     = '0;
    in_flags[PE] = in_inexact;
    in_flags[UE] = in_underflow;
    in_flags[OE] = in_overflow;
    in_flags[ZE] = 1'b0;
    in_flags[DE] = 1'b0;
    in_flags[IE] = in_invalid;
  end

  // Fill level and sticky exception next-state
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    sw_exc_d = clr_exc ? 6'd0 : sw_exc_q;
    if (pop) begin
      sw_exc_d = sw_exc_d | flg_q[head_q];
    end
  end

  // Buffer writes, pointer advance, sticky status and pending indication
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        tw_q[i]   <= TW_VALID;
        tag_q[i]  <= '0;
        flg_q[i]  <= '0;
      end
      head_q   <= 1'b0;
      tail_q   <= 1'b0;
      count_q  <= 2'd0;
      sw_exc_q <= 6'd0;
      pend_q   <= 1'b0;
    end else begin
      if (push) begin
        data_q[tail_q] <= {s_in, conv_exp, conv_mant};
        tw_q[tail_q]   <= conv_tw;
        tag_q[tail_q]  <= in_tag;
        flg_q[tail_q]  <= in_flags;
        tail_q         <= ~tail_q;
      end
      if (pop) begin
        head_q <= ~head_q;
      end
      count_q  <= count_d;
      sw_exc_q <= sw_exc_d;
      pend_q   <= |(sw_exc_d & ~cw_mask);
    end
  end

endmodule

// File: tb/tb_fpu_fp80_pack_wb.sv
// Bench for fpu_fp80_pack_wb: directed conversion vectors, backpressure,
// sticky-flag behaviour, reset mid-operation and a randomized run against a
// queue-based reference model.
module tb_fpu_fp80_pack_wb;

  localparam int TAG_W = 3;
  localparam int EW    = 6 + TAG_W + 2 + 80;  // {flags, tag, tagword, data}

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [63:0]       in_y;
  logic              in_invalid, in_inexact, in_overflow, in_underflow;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [79:0]       out_data;
  logic [1:0]        out_tagword;
  logic [TAG_W-1:0]  out_tag;
  logic [5:0]        cw_mask;
  logic              clr_exc;
  logic [5:0]        sw_exc;
  logic              exc_pending;

  int checks = 0;
  int errors = 0;

  logic [EW-1:0] exp_q[$];

  fpu_fp80_pack_wb #(.TAG_W(TAG_W), .DEPTH(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_y         (in_y),
    .in_invalid   (in_invalid),
    .in_inexact   (in_inexact),
    .in_overflow  (in_overflow),
    .in_underflow (in_underflow),
    .in_tag       (in_tag),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_tagword  (out_tagword),
    .out_tag      (out_tag),
    .cw_mask      (cw_mask),
    .clr_exc      (clr_exc),
    .sw_exc       (sw_exc),
    .exc_pending  (exc_pending)
  );

  // Clock
  always #5 clk = ~clk;

  // Reference conversion from binary64 value semantics: returns {tagword, data}
  function automatic logic [81:0] ref_conv(input logic [63:0] y);
    logic        s;
    int          e;
    logic [51:0] f;
    int          p;
    logic [14:0] ex;
    logic [63:0] m;
    logic [1:0]  tw;
    s = y[63];
    e = int'(y[62:52]);
    f = y[51:0];
    if (e == 2047) begin
      ex = 15'h7FFF;
      tw = 2'b10;
      if (f == 0) m = 64'h8000_0000_0000_0000;
      else        m = 64'hC000_0000_0000_0000 | ({12'b0, f} << 11);
    end else if (e == 0 && f == 0) begin
      ex = 15'd0;
      m  = 64'd0;
      tw = 2'b01;
    end else if (e == 0) begin
      // value = f * 2^-1074; leading one at 2^(p-1074)
      p = 51;
      while (f[p] == 1'b0) p--;
      ex = 15'(p - 1074 + 16383);
      m  = {12'b0, f} << (63 - p);
      tw = 2'b00;
    end else begin
      ex = 15'(e - 1023 + 16383);
      m  = {1'b1, f, 11'b0};
      tw = 2'b00;
    end
    return {tw, s, ex, m};
  endfunction

  function automatic logic [63:0] rand_y();
    logic [63:0] r;
    r = {$urandom, $urandom};
    case ($urandom_range(0, 5))
      0: r[62:52] = 11'd0;
      1: begin r[62:52] = 11'd0; r[51:0] = r[51:0] >> $urandom_range(0, 51);
               if (r[51:0] == 0) r[0] = 1'b1; end
      2: begin r[62:52] = 11'h7FF; r[51:0] = 52'd0; end
      3: begin r[62:52] = 11'h7FF; if (r[51:0] == 0) r[5] = 1'b1; end
      4: r[62:0] = 63'd0;
      default: ;
    endcase
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid     = 1'b0;
    in_y         = 64'd0;
    in_invalid   = 1'b0;
    in_inexact   = 1'b0;
    in_overflow  = 1'b0;
    in_underflow = 1'b0;
    in_tag       = '0;
    out_ready    = 1'b0;
    clr_exc      = 1'b0;
    cw_mask      = 6'h3F;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    checks++; if (out_data !== 80'd0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
    checks++; if (out_tagword !== 2'd0 || out_tag !== '0) begin errors++; $display("FAIL reset_tags got %b/%h want 0/0", out_tagword, out_tag); end
    checks++; if (sw_exc !== 6'd0 || exc_pending !== 1'b0) begin errors++; $display("FAIL reset_sw got %h/%b want 00/0", sw_exc, exc_pending); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_convert();
    logic [63:0] dy [7] = '{64'h3FF0_0000_0000_0000, 64'h0000_0000_0000_0001,
                            64'h8000_0000_0000_0000, 64'h7FF0_0000_0000_0000,
                            64'h7FF4_0000_0000_0000, 64'hC000_0000_0000_0000,
                            64'h0008_0000_0000_0000};
    logic [79:0] dd [7] = '{80'h3FFF_8000_0000_0000_0000, 80'h3BCD_8000_0000_0000_0000,
                            80'h8000_0000_0000_0000_0000, 80'h7FFF_8000_0000_0000_0000,
                            80'h7FFF_E000_0000_0000_0000, 80'hC000_8000_0000_0000_0000,
                            80'h3C00_8000_0000_0000_0000};
    logic [1:0]  dt [7] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00};
    logic [63:0] y;
    logic [81:0] r;
    do_reset();
    for (int i = 0; i < 27; i++) begin
      if (i < 7) begin
        y = dy[i];
        r = {dt[i], dd[i]};
      end else begin
        y = rand_y();
        r = ref_conv(y);
      end
      in_y      = y;
      in_tag    = 3'(i);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL conv_valid[%0d] got %b want 1", i, out_valid); end
      checks++; if (out_data !== r[79:0] || out_tagword !== r[81:80]) begin
        errors++; $display("FAIL conv_data[%0d] y=%h got %h/%b want %h/%b", i, y, out_data, out_tagword, r[79:0], r[81:80]);
      end
      checks++; if (out_tag !== 3'(i)) begin errors++; $display("FAIL conv_tag[%0d] got %h want %h", i, out_tag, 3'(i)); end
      step();
      checks++; if (out_valid !== 1'b0 || sw_exc !== 6'd0) begin
        errors++; $display("FAIL conv_drain[%0d] got valid=%b sw=%h want 0/00", i, out_valid, sw_exc);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] ys [3] = '{64'h3FF0_0000_0000_0000, 64'h4000_0000_0000_0000, 64'hBFF8_0000_0000_0000};
    logic [81:0] r;
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_y   = ys[i];
      in_tag = 3'(i + 1);
      if (i == 2) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_in_ready got %b want 0", in_ready); end
      end
      step();
    end
    r = ref_conv(ys[0]);
    checks++; if (out_data !== r[79:0] || out_tag !== 3'd1) begin errors++; $display("FAIL bp_head_hold got %h/%h want %h/1", out_data, out_tag, r[79:0]); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_still_full got %b want 0", in_ready); end
    out_ready = 1'b1;
    step();
    r = ref_conv(ys[1]);
    checks++; if (out_data !== r[79:0] || out_tag !== 3'd2 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_second got %h/%h rdy=%b want %h/2 rdy=1", out_data, out_tag, in_ready, r[79:0]);
    end
    step();
    in_valid = 1'b0;
    r = ref_conv(ys[2]);
    checks++; if (out_data !== r[79:0] || out_tag !== 3'd3 || out_valid !== 1'b1) begin
      errors++; $display("FAIL bp_third got %h/%h v=%b want %h/3 v=1", out_data, out_tag, out_valid, r[79:0]);
    end
    step();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_empty got v=%b rdy=%b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_flags();
    do_reset();
    cw_mask    = 6'h3F;
    out_ready  = 1'b1;
    in_y       = 64'h3FF0_0000_0000_0000;
    in_inexact = 1'b1;
    in_valid   = 1'b1;
    step();
    in_valid   = 1'b0;
    in_inexact = 1'b0;
    checks++; if (sw_exc !== 6'h00) begin errors++; $display("FAIL flag_before_commit got %h want 00", sw_exc); end
    step();
    checks++; if (sw_exc !== 6'h20 || exc_pending !== 1'b0) begin errors++; $display("FAIL flag_pe got %h/%b want 20/0", sw_exc, exc_pending); end
    cw_mask    = 6'h3E;
    in_invalid = 1'b1;
    in_valid   = 1'b1;
    step();
    in_valid   = 1'b0;
    in_invalid = 1'b0;
    step();
    checks++; if (sw_exc !== 6'h21 || exc_pending !== 1'b1) begin errors++; $display("FAIL flag_ie got %h/%b want 21/1", sw_exc, exc_pending); end
    clr_exc = 1'b1;
    step();
    clr_exc = 1'b0;
    checks++; if (sw_exc !== 6'h00 || exc_pending !== 1'b0) begin errors++; $display("FAIL flag_clear got %h/%b want 00/0", sw_exc, exc_pending); end
    // rebuild sticky state, then clear and commit together
    in_invalid = 1'b1;
    in_valid   = 1'b1;
    step();
    in_valid   = 1'b0;
    in_invalid = 1'b0;
    step();
    out_ready   = 1'b0;
    in_overflow = 1'b1;
    in_valid    = 1'b1;
    step();
    in_valid    = 1'b0;
    in_overflow = 1'b0;
    checks++; if (sw_exc !== 6'h01) begin errors++; $display("FAIL flag_pre_clrpop got %h want 01", sw_exc); end
    out_ready = 1'b1;
    clr_exc   = 1'b1;
    step();
    clr_exc = 1'b0;
    checks++; if (sw_exc !== 6'h08 || exc_pending !== 1'b0) begin errors++; $display("FAIL flag_clr_pop got %h/%b want 08/0", sw_exc, exc_pending); end
    // mask change reaches exc_pending one cycle later
    cw_mask = 6'h37;
    #1;
    checks++; if (exc_pending !== 1'b0) begin errors++; $display("FAIL flag_mask_latency got %b want 0", exc_pending); end
    step();
    checks++; if (exc_pending !== 1'b1) begin errors++; $display("FAIL flag_mask_update got %b want 1", exc_pending); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready    = 1'b1;
    in_y         = 64'h4010_0000_0000_0000;
    in_underflow = 1'b1;
    in_valid     = 1'b1;
    step();
    in_valid     = 1'b0;
    in_underflow = 1'b0;
    step();
    checks++; if (sw_exc !== 6'h10) begin errors++; $display("FAIL rstmid_pre_sw got %h want 10", sw_exc); end
    out_ready  = 1'b0;
    in_invalid = 1'b1;
    in_valid   = 1'b1;
    step();
    step();
    in_valid   = 1'b0;
    in_invalid = 1'b0;
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_full got rdy=%b v=%b want 0/1", in_ready, out_valid); end
    rst       = 1'b1;
    out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0 || sw_exc !== 6'h00 || in_ready !== 1'b0) begin
      errors++; $display("FAIL rstmid_cleared got v=%b sw=%h rdy=%b want 0/00/0", out_valid, sw_exc, in_ready);
    end
    step();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_hold_ready got %b want 0", in_ready); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_release got rdy=%b v=%b want 1/0", in_ready, out_valid); end
  endtask

  task automatic test_random();
    logic [5:0]    sw_m;
    logic          pend_m;
    logic          hold;
    logic          push_m, pop_m;
    logic [EW-1:0] head, ent;
    logic [5:0]    fl;
    logic [81:0]   r;
    do_reset();
    exp_q.delete();
    sw_m = 6'd0;
    hold = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!hold) begin
        in_valid     = ($urandom_range(0, 3) != 0);
        in_y         = rand_y();
        in_invalid   = ($urandom_range(0, 3) == 0);
        in_inexact   = ($urandom_range(0, 3) == 0);
        in_overflow  = ($urandom_range(0, 3) == 0);
        in_underflow = ($urandom_range(0, 3) == 0);
        in_tag       = 3'($urandom_range(0, 7));
      end
      out_ready = ($urandom_range(0, 2) != 0);
      clr_exc   = ($urandom_range(0, 15) == 0);
      cw_mask   = 6'($urandom_range(0, 63));
      #1;
      checks++; if (in_ready !== (exp_q.size() != 2)) begin errors++; $display("FAIL rnd_in_ready[%0d] got %b want %b", cyc, in_ready, exp_q.size() != 2); end
      checks++; if (out_valid !== (exp_q.size() != 0)) begin errors++; $display("FAIL rnd_out_valid[%0d] got %b want %b", cyc, out_valid, exp_q.size() != 0); end
      if (exp_q.size() != 0) begin
        head = exp_q[0];
        checks++; if ({out_tag, out_tagword, out_data} !== head[EW-7:0]) begin
          errors++; $display("FAIL rnd_head[%0d] got %h/%b/%h want %h", cyc, out_tag, out_tagword, out_data, head[EW-7:0]);
        end
      end
      push_m = in_valid && (exp_q.size() != 2);
      pop_m  = out_ready && (exp_q.size() != 0);
      if (clr_exc) sw_m = 6'd0;
      if (pop_m) begin
        head = exp_q.pop_front();
        sw_m = sw_m | head[EW-1:EW-6];
      end
      pend_m = |(sw_m & ~cw_mask);
      if (push_m) begin
        fl  = {in_inexact, in_underflow, in_overflow, 2'b00, in_invalid};
        r   = ref_conv(in_y);
        ent = {fl, in_tag, r};
        exp_q.push_back(ent);
      end
      hold = in_valid && !push_m;
      step();
      checks++; if (sw_exc !== sw_m || exc_pending !== pend_m) begin
        errors++; $display("FAIL rnd_sw[%0d] got %h/%b want %h/%b", cyc, sw_exc, exc_pending, sw_m, pend_m);
      end
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_convert();
    test_back_to_back();
    test_flags();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
